// File: rtl/signal_pipe_fifo.sv
// Elastic pipeline stage for the per-sample signal bundle: a DEPTH-entry circular
// buffer with valid/ready on both sides, global enable, flush and status counters.
module signal_pipe_fifo #(
  parameter int X_WIDTH       = 16,
  parameter int CNT_WIDTH     = 3,
  parameter int DEPTH         = 4,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_flush,
  input  logic                     i_err_clr,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [X_WIDTH-1:0]       i_x_in,
  input  logic                     i_overflow_in,
  input  logic [CNT_WIDTH-1:0]     i_cnt_in,
  input  logic                     i_error_in,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [X_WIDTH-1:0]       o_x_out,
  output logic                     o_overflow_out,
  output logic [CNT_WIDTH-1:0]     o_cnt_out,
  output logic                     o_error_out,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_error_sticky,
  output logic [OVF_CNT_WIDTH-1:0] o_ovf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [X_WIDTH-1:0]       r_x   [DEPTH];
  logic                     r_ovf [DEPTH];
  logic [CNT_WIDTH-1:0]     r_cnt [DEPTH];
  logic                     r_err [DEPTH];
  logic [PW-1:0]            r_wptr;
  logic [PW-1:0]            r_rptr;
  logic [LW-1:0]            r_level;
  logic                     r_error_sticky;
  logic [OVF_CNT_WIDTH-1:0] r_ovf_count;

  logic w_push;
  logic w_pop;

  // Ready is held low while reset is asserted so no beat is offered into a clearing buffer.
  assign o_in_ready  = i_en & i_rst & (r_level != LW'(DEPTH));
  assign o_out_valid = i_en & (r_level != '0);
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  assign o_x_out        = o_out_valid ? r_x[r_rptr]   : '0;
  assign o_overflow_out = o_out_valid ? r_ovf[r_rptr] : 1'b0;
  assign o_cnt_out      = o_out_valid ? r_cnt[r_rptr] : '0;
  assign o_error_out    = o_out_valid ? r_err[r_rptr] : 1'b0;

  assign o_level        = r_level;
  assign o_error_sticky = r_error_sticky;
  assign o_ovf_count    = r_ovf_count;

  // Payload storage needs no reset; unoccupied entries are masked at the head.
  always_ff @(posedge i_clk) begin
    if (i_rst && !i_flush && w_push) begin
      r_x[r_wptr]   <= i_x_in;
      r_ovf[r_wptr] <= i_overflow_in;
      r_cnt[r_wptr] <= i_cnt_in;
      r_err[r_wptr] <= i_error_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_level        <= '0;
      r_error_sticky <= 1'b0;
      r_ovf_count    <= '0;
    end else if (i_flush) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_level        <= '0;
      r_error_sticky <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
      if (w_push && i_error_in) r_error_sticky <= 1'b1;
      else if (i_err_clr)       r_error_sticky <= 1'b0;
      if (w_push && i_overflow_in && (r_ovf_count != '1))
        r_ovf_count <= r_ovf_count + OVF_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_signal_pipe_fifo.sv
// Directed bench for signal_pipe_fifo: a queue-based scoreboard predicts every
// output each cycle and immediate assertions compare against it.
module tb_signal_pipe_fifo;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] x;
    logic        ovf;
    logic [2:0]  cnt;
    logic        err;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, en, flush, errClr, inValid, inReady;
  logic [15:0] xIn;
  logic        ovfIn;
  logic [2:0]  cntIn;
  logic        errIn;
  logic        outValid, outReady;
  logic [15:0] xOut;
  logic        ovfOut;
  logic [2:0]  cntOut;
  logic        errOut;
  logic [2:0]  level;
  logic        errorSticky;
  logic [7:0]  ovfCount;

  beat_t q[$];
  int    modelOvf = 0;
  logic  modelSticky = 1'b0;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  signal_pipe_fifo #(.X_WIDTH(16), .CNT_WIDTH(3), .DEPTH(DEPTH), .OVF_CNT_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush), .i_err_clr(errClr),
    .i_in_valid(inValid), .o_in_ready(inReady), .i_x_in(xIn), .i_overflow_in(ovfIn),
    .i_cnt_in(cntIn), .i_error_in(errIn), .o_out_valid(outValid), .i_out_ready(outReady),
    .o_x_out(xOut), .o_overflow_out(ovfOut), .o_cnt_out(cntOut), .o_error_out(errOut),
    .o_level(level), .o_error_sticky(errorSticky), .o_ovf_count(ovfCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Check all outputs against the model, then advance one edge and update the model.
  task automatic applyStimulus(input logic vRst, input logic vEn, input logic vFlush,
                               input logic vErrClr, input logic vInValid, input logic [15:0] vX,
                               input logic vOvf, input logic [2:0] vCnt, input logic vErr,
                               input logic vOutReady);
    beat_t head;
    logic  expReady, expValid, doPush, doPop;
    rst = vRst; en = vEn; flush = vFlush; errClr = vErrClr; inValid = vInValid;
    xIn = vX; ovfIn = vOvf; cntIn = vCnt; errIn = vErr; outReady = vOutReady;
    #1;
    expReady = vRst && vEn && (q.size() != DEPTH);
    expValid = vEn && (q.size() != 0);
    head = expValid ? q[0] : '0;
    checkOutput("in_ready", 32'(inReady), 32'(expReady));
    checkOutput("out_valid", 32'(outValid), 32'(expValid));
    checkOutput("level", 32'(level), 32'(q.size()));
    checkOutput("x_out", 32'(xOut), 32'(head.x));
    checkOutput("overflow_out", 32'(ovfOut), 32'(head.ovf));
    checkOutput("cnt_out", 32'(cntOut), 32'(head.cnt));
    checkOutput("error_out", 32'(errOut), 32'(head.err));
    checkOutput("error_sticky", 32'(errorSticky), 32'(modelSticky));
    checkOutput("ovf_count", 32'(ovfCount), 32'(modelOvf));
    doPush = vInValid && expReady;
    doPop  = vOutReady && expValid;
    @(posedge clk);
    if (!vRst) begin
      q.delete();
      modelSticky = 1'b0;
      modelOvf = 0;
    end else if (vFlush) begin
      q.delete();
      modelSticky = 1'b0;
    end else begin
      if (doPop) void'(q.pop_front());
      if (doPush) q.push_back('{x: vX, ovf: vOvf, cnt: vCnt, err: vErr});
      if (doPush && vOvf && modelOvf < 255) modelOvf++;
      if (doPush && vErr) modelSticky = 1'b1;
      else if (vErrClr) modelSticky = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; flush = 1'b0; errClr = 1'b0; inValid = 1'b0;
    xIn = '0; ovfIn = 1'b0; cntIn = '0; errIn = 1'b0; outReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Reset held: checks reset values and in_ready low.
    applyStimulus(0, 1, 0, 0, 1, 16'h5555, 0, 3'd1, 0, 0);

    // Single beat through an empty buffer.
    applyStimulus(1, 1, 0, 0, 1, 16'h1234, 0, 3'd5, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 16'h0000, 0, 3'd0, 0, 0);
    checkOutput("single_x", 32'(xOut), 32'h1234);
    applyStimulus(1, 1, 0, 0, 0, 16'h0000, 0, 3'd0, 0, 1);
    checkOutput("single_drained", 32'(level), 32'd0);

    // Fill to full; the fifth beat is refused.
    for (int i = 1; i <= 5; i++)
      applyStimulus(1, 1, 0, 0, 1, 16'(i), 0, 3'(i), 0, 0);
    checkOutput("full_ready", 32'(inReady), 32'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 0, 0, 0, 16'h0, 0, 3'd0, 0, 1);
    checkOutput("drained_empty", 32'(q.size()), 32'd0);

    // Sustained streaming with pointer wrap.
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 1, 0, 0, 1, 16'($urandom), 0, 3'($urandom_range(0, 7)), 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 16'h0, 0, 3'd0, 0, 1);

    // Enable low with two entries buffered.
    applyStimulus(1, 1, 0, 0, 1, 16'hA001, 0, 3'd2, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 16'hA002, 1, 3'd3, 1, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 0, 0, 1, 16'hDEAD, 1, 3'd7, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 16'h0, 0, 3'd0, 0, 0);
    checkOutput("en_head_back", 32'(xOut), 32'hA001);
    applyStimulus(1, 1, 1, 0, 0, 16'h0, 0, 3'd0, 0, 0);

    // Overflow counter saturation and sticky error behaviour.
    for (int i = 0; i < 300; i++)
      applyStimulus(1, 1, 0, 0, 1, 16'(i), 1, 3'(i), 0, 1);
    checkOutput("ovf_saturated", 32'(ovfCount), 32'd255);
    applyStimulus(1, 1, 0, 0, 1, 16'hE001, 0, 3'd1, 1, 1);
    applyStimulus(1, 1, 0, 1, 1, 16'hE002, 0, 3'd2, 1, 0);
    checkOutput("sticky_set_wins", 32'(errorSticky), 32'd1);
    applyStimulus(1, 1, 1, 0, 0, 16'h0, 0, 3'd0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 16'h0, 0, 3'd0, 0, 0);
    checkOutput("flush_keeps_ovf", 32'(ovfCount), 32'd255);

    // Mid-operation reset with three entries buffered.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 0, 0, 1, 16'(16'hC000 + i), 0, 3'(i), 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 16'hBEEF, 1, 3'd4, 1, 0);
    checkOutput("reset_level", 32'(level), 32'd0);
    applyStimulus(1, 1, 0, 0, 1, 16'hABCD, 0, 3'd6, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 16'h0, 0, 3'd0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 16'h0, 0, 3'd0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
